// File: rtl/de_write_combiner.sv
// Byte-write combiner between the draw engine and frame store: merges same-word
// byte writes into one masked word write, queues them, and orders reads behind writes.
module de_write_combiner #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_FLUSH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_req,
    output logic        de_ack,
    input  logic [17:0] de_addr,
    input  logic [3:0]  de_nbyte,
    input  logic        de_rnw,
    input  logic [31:0] de_w_data,
    output logic [31:0] de_r_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [17:0] mem_addr,
    output logic [3:0]  mem_nbyte,
    output logic        mem_rnw,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data,
    output logic        drained
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int IW = $clog2(IDLE_FLUSH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] FLUSH_AT = IW'(IDLE_FLUSH - 1);

    logic          hold_valid_q;
    logic [17:0]   hold_addr_q;
    logic [3:0]    hold_mask_q;
    logic [31:0]   hold_data_q;
    logic [IW-1:0] idle_cnt_q;

    logic [17:0]   fifo_addr_q [FIFO_DEPTH];
    logic [3:0]    fifo_mask_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic        fifo_empty;
    logic        fifo_full;
    logic        wr_req;
    logic        rd_req;
    logic        wr_null;
    logic [3:0]  wr_mask;
    logic        addr_hit;
    logic        wr_ok;
    logic        wr_acc;
    logic        wr_push;
    logic        flush_push;
    logic        push;
    logic        pop;
    logic        rd_fwd;
    logic [3:0]  hold_mask_d;
    logic [31:0] hold_data_d;

    // rst_n gates the request so nothing is acknowledged or forwarded while in reset.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign wr_req     = rst_n && de_req && !de_rnw;
    assign rd_req     = rst_n && de_req && de_rnw;
    assign wr_null    = (de_nbyte == 4'b1111);
    assign wr_mask    = ~de_nbyte;
    assign addr_hit   = hold_valid_q && (de_addr == hold_addr_q);
    assign wr_ok      = wr_null || !hold_valid_q || addr_hit || !fifo_full;
    assign wr_acc     = wr_req && wr_ok && !wr_null;
    assign wr_push    = wr_acc && hold_valid_q && !addr_hit;
    assign flush_push = hold_valid_q && !fifo_full && !wr_acc &&
                        ((idle_cnt_q == FLUSH_AT) || rd_req);
    assign push       = wr_push || flush_push;
    assign pop        = !fifo_empty && mem_ack;
    assign rd_fwd     = rd_req && !hold_valid_q && fifo_empty;

    assign de_ack    = (wr_req && wr_ok) || (rd_fwd && mem_ack);
    assign de_r_data = rd_fwd ? mem_r_data : 32'h0;
    assign drained   = !hold_valid_q && fifo_empty && !rd_fwd;

    assign hold_mask_d = addr_hit ? (hold_mask_q | wr_mask) : wr_mask;

    // Newest byte wins; untouched lanes keep the held word on a hit, else clear.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign hold_data_d[8*gi +: 8] = wr_mask[gi] ? de_w_data[8*gi +: 8] :
                                        (addr_hit ? hold_data_q[8*gi +: 8] : 8'h00);
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_addr   = 18'h0;
        mem_nbyte  = 4'b1111;
        mem_rnw    = 1'b0;
        mem_w_data = 32'h0;
        if (!fifo_empty) begin
            mem_req    = 1'b1;
            mem_addr   = fifo_addr_q[rd_ptr_q];
            mem_nbyte  = ~fifo_mask_q[rd_ptr_q];
            mem_w_data = fifo_data_q[rd_ptr_q];
        end else if (rd_fwd) begin
            mem_req   = 1'b1;
            mem_addr  = de_addr;
            mem_nbyte = de_nbyte;
            mem_rnw   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= 18'h0;
            hold_mask_q  <= 4'h0;
            hold_data_q  <= 32'h0;
            idle_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            if (wr_acc) begin
                hold_valid_q <= 1'b1;
                hold_addr_q  <= de_addr;
                hold_mask_q  <= hold_mask_d;
                hold_data_q  <= hold_data_d;
                idle_cnt_q   <= '0;
            end else if (flush_push) begin
                hold_valid_q <= 1'b0;
                hold_mask_q  <= 4'h0;
                idle_cnt_q   <= '0;
            end else if (hold_valid_q && (idle_cnt_q != FLUSH_AT)) begin
                idle_cnt_q <= idle_cnt_q + IW'(1);
            end

            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= hold_addr_q;
            fifo_mask_q[wr_ptr_q] <= hold_mask_q;
            fifo_data_q[wr_ptr_q] <= hold_data_q;
        end
    end
endmodule
